// File: rtl/lsu_axi4l.sv
// Load/store unit between EXU and WBU: one AXI4-Lite read or write per memory op,
// with lane alignment, WSTRB generation, load extension and fault reporting.
module lsu_axi4l #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned PASS_W = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                exu_valid,
    output logic                lsu_ready,
    input  logic [ADDR_W-1:0]   exu_addr,
    input  logic                exu_ren,
    input  logic                exu_wen,
    input  logic [2:0]          exu_op,
    input  logic [XLEN-1:0]     exu_wdata,
    input  logic [PASS_W-1:0]   exu_pass,
    output logic                lsu_valid,
    input  logic                wbu_ready,
    output logic [ADDR_W-1:0]   lsu_addr,
    output logic [XLEN-1:0]     lsu_rdata,
    output logic [1:0]          lsu_fault,
    output logic [PASS_W-1:0]   lsu_pass,
    output logic                prerequest,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [XLEN-1:0]     RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RVALID,
    output logic                RREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [XLEN-1:0]     WDATA,
    output logic [XLEN/8-1:0]   WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);

    localparam int unsigned OFS_W  = $clog2(XLEN/8);
    localparam int unsigned STRB_W = XLEN/8;

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, DONE} state_t;

    state_t          state;
    logic [2:0]      op_q;

    logic             mem_c;
    logic             misalign_c;
    logic [OFS_W-1:0] acc_ofs_c;
    logic [STRB_W-1:0] size_mask_c;
    logic [STRB_W-1:0] strb_c;
    logic [XLEN-1:0]  wdata_sh_c;
    logic [OFS_W-1:0] rd_ofs_c;
    logic [XLEN-1:0]  rsh_c;
    logic [XLEN-1:0]  keep_c;
    logic             sbit_c;
    logic [XLEN-1:0]  rext_c;
    logic             aw_done_c;
    logic             w_done_c;
    logic             unused_c;

    assign mem_c      = exu_ren | exu_wen;
    assign acc_ofs_c  = exu_addr[OFS_W-1:0];
    assign prerequest = exu_valid & lsu_ready & mem_c;
    assign unused_c   = ^{RRESP[0], BRESP[0]};

    // Alignment check and store lane placement for the op being offered
    always_comb begin
        misalign_c  = 1'b0;
        size_mask_c = STRB_W'(8'h01);
        case (exu_op[1:0])
            2'b00: begin
                misalign_c  = 1'b0;
                size_mask_c = STRB_W'(8'h01);
            end
            2'b01: begin
                misalign_c  = exu_addr[0];
                size_mask_c = STRB_W'(8'h03);
            end
            2'b10: begin
                misalign_c  = |exu_addr[1:0];
                size_mask_c = STRB_W'(8'h0f);
            end
            default: begin
                misalign_c  = (XLEN < 64) ? 1'b1 : |exu_addr[2:0];
                size_mask_c = STRB_W'(8'hff);
            end
        endcase
        strb_c     = size_mask_c << acc_ofs_c;
        wdata_sh_c = exu_wdata << {acc_ofs_c, 3'b000};
    end

    // Load lane extraction and sign/zero extension from the latched address and op
    always_comb begin
        rd_ofs_c = lsu_addr[OFS_W-1:0];
        rsh_c    = RDATA >> {rd_ofs_c, 3'b000};
        keep_c   = '1;
        sbit_c   = 1'b0;
        case (op_q[1:0])
            2'b00: begin
                keep_c = XLEN'(8'hff);
                sbit_c = rsh_c[7];
            end
            2'b01: begin
                keep_c = XLEN'(16'hffff);
                sbit_c = rsh_c[15];
            end
            2'b10: begin
                keep_c = XLEN'(32'hffff_ffff);
                sbit_c = rsh_c[31];
            end
            default: begin
                keep_c = '1;
                sbit_c = 1'b0;
            end
        endcase
        rext_c = (rsh_c & keep_c) | (~keep_c & {XLEN{sbit_c & ~op_q[2]}});
    end

    assign aw_done_c = ~AWVALID | AWREADY;
    assign w_done_c  = ~WVALID  | WREADY;

    // Control FSM; every output above prerequest is a register here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op_q      <= '0;
            lsu_ready <= 1'b1;
            lsu_valid <= 1'b0;
            lsu_addr  <= '0;
            lsu_rdata <= '0;
            lsu_fault <= '0;
            lsu_pass  <= '0;
            ARADDR    <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            AWADDR    <= '0;
            AWVALID   <= 1'b0;
            WDATA     <= '0;
            WSTRB     <= '0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (exu_valid) begin
                        lsu_ready <= 1'b0;
                        lsu_addr  <= exu_addr;
                        lsu_pass  <= exu_pass;
                        op_q      <= exu_op;
                        lsu_rdata <= '0;
                        lsu_fault <= 2'b00;
                        if (!mem_c) begin
                            lsu_valid <= 1'b1;
                            state     <= DONE;
                        end else if (misalign_c) begin
                            lsu_fault <= 2'b01;
                            lsu_valid <= 1'b1;
                            state     <= DONE;
                        end else if (exu_ren) begin
                            ARADDR  <= exu_addr;
                            ARVALID <= 1'b1;
                            state   <= RD_A;
                        end else begin
                            AWADDR  <= exu_addr;
                            AWVALID <= 1'b1;
                            WDATA   <= wdata_sh_c;
                            WSTRB   <= strb_c;
                            WVALID  <= 1'b1;
                            state   <= WR;
                        end
                    end
                end
                RD_A: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= RD_D;
                    end
                end
                RD_D: begin
                    if (RVALID) begin
                        RREADY    <= 1'b0;
                        lsu_valid <= 1'b1;
                        state     <= DONE;
                        if (RRESP[1]) begin
                            lsu_fault <= 2'b10;
                        end else begin
                            lsu_rdata <= rext_c;
                        end
                    end
                end
                WR: begin
                    // AW and W complete independently, possibly on the same edge
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                    end
                    if (WREADY) begin
                        WVALID <= 1'b0;
                    end
                    if (aw_done_c && w_done_c) begin
                        BREADY <= 1'b1;
                        state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (BVALID) begin
                        BREADY    <= 1'b0;
                        lsu_valid <= 1'b1;
                        state     <= DONE;
                        if (BRESP[1]) begin
                            lsu_fault <= 2'b10;
                        end
                    end
                end
                DONE: begin
                    if (wbu_ready) begin
                        lsu_valid <= 1'b0;
                        lsu_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi4l.sv
// Bench for lsu_axi4l: vector table driven through the EXU port, AXI4-Lite slave
// model with per-op response/delay settings, and a WBU-side scoreboard.
module tb_lsu_axi4l;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic        lsu_ready;
    logic [31:0] exu_addr;
    logic        exu_ren;
    logic        exu_wen;
    logic [2:0]  exu_op;
    logic [31:0] exu_wdata;
    logic [39:0] exu_pass;
    logic        lsu_valid;
    logic        wbu_ready;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_fault;
    logic [39:0] lsu_pass;
    logic        prerequest;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    lsu_axi4l dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .lsu_ready(lsu_ready), .exu_addr(exu_addr),
        .exu_ren(exu_ren), .exu_wen(exu_wen), .exu_op(exu_op),
        .exu_wdata(exu_wdata), .exu_pass(exu_pass),
        .lsu_valid(lsu_valid), .wbu_ready(wbu_ready), .lsu_addr(lsu_addr),
        .lsu_rdata(lsu_rdata), .lsu_fault(lsu_fault), .lsu_pass(lsu_pass),
        .prerequest(prerequest),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ren;
        logic        wen;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rbus;
        logic [1:0]  resp;
        int          aw_dly;
        int          w_dly;
        int          hold;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_fault;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic        exp_bus;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [1:0]  fault;
        logic [39:0] pass;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int cur_idx  = -1;

    // Slave configuration for the current op and what it observed
    logic [31:0] cur_rbus;
    logic [1:0]  cur_resp;
    int          cur_aw_dly;
    int          cur_w_dly;
    logic        r_stall;
    int          n_ar = 0;
    int          n_b  = 0;
    logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
    logic [3:0]  seen_wstrb;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL vec%0d %s: got %h expected %h", cur_idx, nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ren, input logic wen, input logic [2:0] op,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rbus, input logic [1:0] resp,
                                input int aw_dly, input int w_dly, input int hold,
                                input logic [31:0] exp_rdata, input logic [1:0] exp_fault,
                                input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                                input logic exp_bus);
        vec_t v;
        v.ren = ren; v.wen = wen; v.op = op; v.addr = addr; v.wdata = wdata;
        v.rbus = rbus; v.resp = resp; v.aw_dly = aw_dly; v.w_dly = w_dly; v.hold = hold;
        v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.exp_strb = exp_strb;
        v.exp_wdata = exp_wdata; v.exp_bus = exp_bus;
        return v;
    endfunction

    // Read slave: one-cycle ARREADY, RVALID after AR unless stalled
    initial begin : rd_slave
        logic ar_pend, r_pend, rv_want;
        logic [31:0] ar_addr_q;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0;
        ar_pend = 1'b0; r_pend = 1'b0; rv_want = 1'b0; ar_addr_q = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ARREADY = 1'b0; RVALID = 1'b0;
                ar_pend = 1'b0; r_pend = 1'b0; rv_want = 1'b0;
            end else begin
                if (ar_pend) begin
                    ARREADY = 1'b0;
                    n_ar++;
                    seen_araddr = ar_addr_q;
                    rv_want = 1'b1;
                end else if (ARVALID && !ARREADY) begin
                    ARREADY = 1'b1;
                end
                if (r_pend) begin
                    RVALID = 1'b0;
                end else if (rv_want && !r_stall && !RVALID) begin
                    RVALID = 1'b1;
                    RDATA  = cur_rbus;
                    RRESP  = cur_resp;
                    rv_want = 1'b0;
                end
                ar_pend   = ARVALID && ARREADY;
                ar_addr_q = ARADDR;
                r_pend    = RVALID && RREADY;
            end
        end
    end

    // Write slave: AWREADY/WREADY after per-op delays, B after both handshakes
    initial begin : wr_slave
        logic aw_pend, w_pend, b_pend, aw_got, w_got;
        int aw_cnt, w_cnt;
        logic [31:0] aw_addr_q, w_data_q;
        logic [3:0]  w_strb_q;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = '0;
        aw_pend = 1'b0; w_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        aw_cnt = 0; w_cnt = 0; aw_addr_q = '0; w_data_q = '0; w_strb_q = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
                aw_pend = 1'b0; w_pend = 1'b0; b_pend = 1'b0;
                aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0;
            end else begin
                if (aw_pend) begin
                    AWREADY = 1'b0; aw_got = 1'b1; aw_cnt = 0;
                    seen_awaddr = aw_addr_q;
                end else if (AWVALID && !AWREADY) begin
                    if (aw_cnt >= cur_aw_dly) AWREADY = 1'b1;
                    else aw_cnt++;
                end
                if (w_pend) begin
                    WREADY = 1'b0; w_got = 1'b1; w_cnt = 0;
                    seen_wdata = w_data_q; seen_wstrb = w_strb_q;
                end else if (WVALID && !WREADY) begin
                    if (w_cnt >= cur_w_dly) WREADY = 1'b1;
                    else w_cnt++;
                end
                if (b_pend) begin
                    BVALID = 1'b0;
                    n_b++;
                end else if (aw_got && w_got && !BVALID) begin
                    BVALID = 1'b1; BRESP = cur_resp;
                    aw_got = 1'b0; w_got = 1'b0;
                end
                aw_pend = AWVALID && AWREADY; aw_addr_q = AWADDR;
                w_pend  = WVALID && WREADY;   w_data_q = WDATA; w_strb_q = WSTRB;
                b_pend  = BVALID && BREADY;
            end
        end
    end

    task automatic check_reset();
        chk("rst_ctrl", {ARVALID, RREADY, AWVALID, WVALID, BREADY, lsu_valid, lsu_ready}, 7'b0000001);
        chk("rst_lsu_addr", lsu_addr, 0);
        chk("rst_rdata", lsu_rdata, 0);
        chk("rst_fault", lsu_fault, 0);
        chk("rst_pass", lsu_pass, 0);
        chk("rst_bus_addr", {ARADDR, AWADDR}, 0);
        chk("rst_wbus", {WDATA, WSTRB}, 0);
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        int lat, ar0, b0;
        @(negedge clk);
        lat = 0;
        while (!lsu_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        cur_rbus = v.rbus; cur_resp = v.resp; cur_aw_dly = v.aw_dly; cur_w_dly = v.w_dly;
        exu_ren = v.ren; exu_wen = v.wen; exu_op = v.op; exu_addr = v.addr;
        exu_wdata = v.wdata; exu_pass = {8'h5A, v.addr}; exu_valid = 1'b1;
        #1;
        chk("prerequest", prerequest, v.ren | v.wen);
        e.addr = v.addr; e.rdata = v.exp_rdata; e.fault = v.exp_fault; e.pass = {8'h5A, v.addr};
        sb.push_back(e);
        ar0 = n_ar; b0 = n_b;
        @(negedge clk);
        exu_valid = 1'b0; exu_ren = 1'b0; exu_wen = 1'b0;
        lat = 0;
        while (!lsu_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!lsu_valid) begin
            chk("timeout_lsu_valid", 0, 1);
            sb.delete();
            return;
        end
        if (!v.exp_bus) chk("latency", lat, 0);
        for (int h = 0; h < v.hold; h++) begin
            chk("hold_valid", lsu_valid, 1);
            chk("hold_ready", lsu_ready, 0);
            chk("hold_addr", lsu_addr, sb[0].addr);
            chk("hold_rdata", lsu_rdata, sb[0].rdata);
            chk("hold_fault", lsu_fault, sb[0].fault);
            @(negedge clk);
        end
        wbu_ready = 1'b1;
        e = sb.pop_front();
        chk("lsu_addr", lsu_addr, e.addr);
        chk("lsu_rdata", lsu_rdata, e.rdata);
        chk("lsu_fault", lsu_fault, e.fault);
        chk("lsu_pass", lsu_pass, e.pass);
        chk("ready_in_done", lsu_ready, 0);
        @(negedge clk);
        wbu_ready = 1'b0;
        chk("handoff", {lsu_valid, lsu_ready}, 2'b01);
        chk("ar_count", n_ar - ar0, v.exp_bus & v.ren);
        chk("b_count", n_b - b0, v.exp_bus & v.wen);
        if (v.exp_bus && v.ren) chk("araddr", seen_araddr, v.addr);
        if (v.exp_bus && v.wen) begin
            chk("awaddr", seen_awaddr, v.addr);
            chk("wstrb", seen_wstrb, v.exp_strb);
            chk("wdata", seen_wdata, v.exp_wdata);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b0; exu_valid = 1'b0; exu_addr = '0; exu_ren = 1'b0; exu_wen = 1'b0;
        exu_op = '0; exu_wdata = '0; exu_pass = '0; wbu_ready = 1'b0;
        cur_rbus = '0; cur_resp = '0; cur_aw_dly = 0; cur_w_dly = 0; r_stall = 1'b0;
        seen_araddr = '0; seen_awaddr = '0; seen_wdata = '0; seen_wstrb = '0;

        //                ren   wen   op      addr          wdata         rbus          resp  aw w hold exp_rdata     flt    strb   exp_wdata     bus
        vecs.push_back(mk(1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'h0,        32'h0,        2'b00, 0, 0, 0, 32'h0,        2'b00, 4'h0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0,        32'h80FF_FFFF, 2'b00, 0, 0, 0, 32'hFFFF_FF80, 2'b00, 4'h0, 32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0,        32'h80FF_FFFF, 2'b00, 0, 0, 0, 32'h0000_0080, 2'b00, 4'h0, 32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0,        32'h8001_1234, 2'b00, 0, 0, 0, 32'hFFFF_8001, 2'b00, 4'h0, 32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0,        32'h8001_1234, 2'b00, 0, 0, 0, 32'h0000_8001, 2'b00, 4'h0, 32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 2'b00, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 4'h0, 32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0,        32'hDEAD_BEEF, 2'b00, 0, 0, 0, 32'h0,        2'b01, 4'h0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0,        32'h1111_1111, 2'b10, 0, 0, 0, 32'h0,        2'b10, 4'h0, 32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 3'b010, 32'h8000_000C, 32'h0,        32'h0BAD_F00D, 2'b01, 0, 0, 0, 32'h0BAD_F00D, 2'b00, 4'h0, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h0,       2'b00, 0, 3, 0, 32'h0,        2'b00, 4'hC, 32'hABCD_0000, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_5678, 32'h0,       2'b00, 1, 1, 0, 32'h0,        2'b00, 4'h2, 32'h3456_7800, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0,       2'b11, 2, 0, 0, 32'h0,        2'b10, 4'hF, 32'hCAFE_F00D, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'b011, 32'h8000_0000, 32'h5555_5555, 32'h0,       2'b00, 0, 0, 0, 32'h0,        2'b01, 4'h0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0,        32'h0000_7F00, 2'b00, 0, 0, 5, 32'h0000_007F, 2'b00, 4'h0, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'b001, 32'h8000_0003, 32'h0000_1111, 32'h0,       2'b00, 0, 0, 0, 32'h0,        2'b01, 4'h0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 3'b100, 32'h8000_0000, 32'h0,        32'h0000_00FF, 2'b00, 0, 0, 0, 32'h0000_00FF, 2'b00, 4'h0, 32'h0,        1'b1));

        repeat (3) @(negedge clk);
        #1;
        check_reset();
        chk("rst_prerequest", prerequest, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            cur_idx = i;
            run(vecs[i]);
        end

        // Reset while the load waits in the data phase
        cur_idx = 100;
        @(negedge clk);
        r_stall = 1'b1; cur_rbus = 32'h7777_7777; cur_resp = 2'b00;
        exu_ren = 1'b1; exu_op = 3'b010; exu_addr = 32'h8000_0010;
        exu_pass = 40'hA5_8000_0010; exu_valid = 1'b1;
        @(negedge clk);
        exu_valid = 1'b0; exu_ren = 1'b0;
        lat = 0;
        while (!RREADY && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("reached_rd_d", RREADY, 1);
        rst = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        @(negedge clk);
        r_stall = 1'b0;
        rst = 1'b1;
        cur_idx = 101;
        run(vecs[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
